// File: rtl/match_scanner_if.sv
// match_scanner_if: cell load handshake plus scan result bus for match_scanner.
// The bad_cell signal exists only when MATCH_SCANNER_BAD_CELL_EN is defined.
interface match_scanner_if;
    logic        cell_valid;
    logic [2:0]  cell_data;
    logic        cell_ready;
    logic        busy;
    logic        done;
    logic [63:0] clear_mask;
    logic [6:0]  match_cnt;
`ifdef MATCH_SCANNER_BAD_CELL_EN
    logic        bad_cell;
`endif

    // Board source side: offers cells, observes scan results.
    modport master (
        output cell_valid,
        output cell_data,
        input  cell_ready,
        input  busy,
        input  done,
        input  clear_mask,
`ifdef MATCH_SCANNER_BAD_CELL_EN
        input  bad_cell,
`endif
        input  match_cnt
    );

    // Scanner side: accepts cells, publishes results.
    modport slave (
        input  cell_valid,
        input  cell_data,
        output cell_ready,
        output busy,
        output done,
        output clear_mask,
`ifdef MATCH_SCANNER_BAD_CELL_EN
        output bad_cell,
`endif
        output match_cnt
    );
endinterface

// File: rtl/match_scanner.sv
// match_scanner: loads an 8x8 board of 3-bit colours row-major, then scans one
// row per cycle and one column per cycle, marking every cell that lies in a
// maximal run of at least RUN_MIN equal colours (1..6). Colours 0 and 7 never
// match and break runs. Row and column marks are OR-ed into clear_mask.
// Optional feature: define MATCH_SCANNER_BAD_CELL_EN to add the sticky
// bad_cell flag raised when a board contains colour 0 or 7.
module match_scanner #(
    parameter int RUN_MIN = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    match_scanner_if.slave bus
);

    typedef enum logic [1:0] {LOAD, SCAN_ROW, SCAN_COL, DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cellIdx;
    logic [2:0]  r_lineIdx;
    logic [2:0]  r_board [64];
    logic        r_cellReady;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_clearMask;
    logic [6:0]  r_matchCnt;
`ifdef MATCH_SCANNER_BAD_CELL_EN
    logic        r_badCell;
    logic        w_illegal;
`endif

    logic        w_accept;
    logic [23:0] w_line;
    logic [7:0]  w_lineMarks;
    logic [63:0] w_maskAdd;
    logic [63:0] w_nextMask;
    logic [6:0]  w_nextCnt;

    // Marks cells of one 8-cell line that belong to a long enough run.
    // runL/runR hold the run length ending/starting at each position, so a
    // cell's full run length is runL + runR - 1.
    function automatic logic [7:0] lineMarks(input logic [23:0] lineBits);
        logic [2:0] colour [8];
        logic [7:0] legal;
        logic [3:0] runL [8];
        logic [3:0] runR [8];
        logic [7:0] marks;
        for (int i = 0; i < 8; i++) begin
            colour[i] = lineBits[i*3 +: 3];
            legal[i]  = (colour[i] != 3'd0) && (colour[i] != 3'd7);
        end
        runL[0] = legal[0] ? 4'd1 : 4'd0;
        for (int i = 1; i < 8; i++) begin
            if (!legal[i])
                runL[i] = 4'd0;
            else if (colour[i] == colour[i-1])
                runL[i] = runL[i-1] + 4'd1;
            else
                runL[i] = 4'd1;
        end
        runR[7] = legal[7] ? 4'd1 : 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!legal[i])
                runR[i] = 4'd0;
            else if (colour[i] == colour[i+1])
                runR[i] = runR[i+1] + 4'd1;
            else
                runR[i] = 4'd1;
        end
        for (int i = 0; i < 8; i++) begin
            marks[i] = legal[i] &&
                       (({1'b0, runL[i]} + {1'b0, runR[i]}) > 5'(RUN_MIN));
        end
        return marks;
    endfunction

    // Number of set bits in a 64-bit mask (0..64).
    function automatic logic [6:0] popCount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    assign w_accept    = bus.cell_valid & r_cellReady;
    assign w_lineMarks = lineMarks(w_line);
    assign w_nextMask  = r_clearMask | w_maskAdd;
    assign w_nextCnt   = popCount(w_nextMask);
`ifdef MATCH_SCANNER_BAD_CELL_EN
    assign w_illegal   = (bus.cell_data == 3'd0) || (bus.cell_data == 3'd7);
`endif

    // Gather the row or column currently being scanned from the board array.
    always_comb begin
        w_line = '0;
        for (int c = 0; c < 8; c++) begin
            if (r_state == SCAN_COL)
                w_line[c*3 +: 3] = r_board[{3'(c), r_lineIdx}];
            else
                w_line[c*3 +: 3] = r_board[{r_lineIdx, 3'(c)}];
        end
    end

    // Scatter the line's marks back to their board bit positions.
    always_comb begin
        w_maskAdd = '0;
        for (int c = 0; c < 8; c++) begin
            if (r_state == SCAN_COL)
                w_maskAdd[{3'(c), r_lineIdx}] = w_lineMarks[c];
            else if (r_state == SCAN_ROW)
                w_maskAdd[{r_lineIdx, 3'(c)}] = w_lineMarks[c];
        end
    end

    // Board storage; left unreset since a reset restarts loading at index 0.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_board[r_cellIdx] <= bus.cell_data;
    end

    // Main FSM: load 64 cells, scan 8 rows, scan 8 columns, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_cellIdx   <= '0;
            r_lineIdx   <= '0;
            r_cellReady <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clearMask <= '0;
            r_matchCnt  <= '0;
`ifdef MATCH_SCANNER_BAD_CELL_EN
            r_badCell   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_cellIdx <= r_cellIdx + 6'd1;
                        if (r_cellIdx == 6'd0) begin
                            r_clearMask <= '0;
                            r_matchCnt  <= '0;
                        end
`ifdef MATCH_SCANNER_BAD_CELL_EN
                        if (r_cellIdx == 6'd0)
                            r_badCell <= w_illegal;
                        else
                            r_badCell <= r_badCell | w_illegal;
`endif
                        if (r_cellIdx == 6'd63) begin
                            r_state     <= SCAN_ROW;
                            r_lineIdx   <= '0;
                            r_cellReady <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                SCAN_ROW: begin
                    r_clearMask <= w_nextMask;
                    r_lineIdx   <= r_lineIdx + 3'd1;
                    if (r_lineIdx == 3'd7)
                        r_state <= SCAN_COL;
                end
                SCAN_COL: begin
                    r_clearMask <= w_nextMask;
                    r_lineIdx   <= r_lineIdx + 3'd1;
                    if (r_lineIdx == 3'd7) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_matchCnt <= w_nextCnt;
                    end
                end
                DONE: begin
                    r_state     <= LOAD;
                    r_cellReady <= 1'b1;
                end
                default: begin
                    r_state     <= LOAD;
                    r_cellReady <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cell_ready = r_cellReady;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.clear_mask = r_clearMask;
    assign bus.match_cnt  = r_matchCnt;
`ifdef MATCH_SCANNER_BAD_CELL_EN
    assign bus.bad_cell   = r_badCell;
`endif

endmodule

// File: tb/tb_match_scanner.sv
// tb_match_scanner: table-driven boards with hand-derived results, random
// boards checked against a run-finding reference model, plus mid-scan reset
// and back-to-back load sequences.
module tb_match_scanner;
    localparam int RUN_MIN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cycleCnt = 0;
    int   nVectors = 0;
    int   nMiscompares = 0;

    logic [2:0] stimBoard [64];
    logic [2:0] seqCells [128];

    match_scanner_if ifc();

    match_scanner #(.RUN_MIN(RUN_MIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Rising-edge counter used to measure latencies.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] expMask;
        int          expCnt;
        bit          expBad;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Base pattern (r+c)%6+1 has no two equal neighbours; kinds overlay runs.
    task automatic buildBoard(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                stimBoard[r*8+c] = 3'((r + c) % 6 + 1);
        case (kind)
            1: for (int c = 0; c < 5; c++) stimBoard[16+c] = 3'd5;
            2: for (int k = 2; k < 5; k++) begin
                   stimBoard[24+k]  = 3'd4;
                   stimBoard[k*8+3] = 3'd4;
               end
            3: for (int c = 0; c < 8; c++) stimBoard[c] = 3'd0;
            4: for (int c = 0; c < 8; c++) stimBoard[c] = 3'd7;
            5: for (int i = 0; i < 64; i++) stimBoard[i] = 3'd1;
            6: stimBoard[41] = 3'd6;
            7: for (int c = 0; c < 8; c++) stimBoard[56+c] = 3'd3;
            8: for (int r = 5; r < 8; r++) stimBoard[r*8+7] = 3'd6;
            default: ;
        endcase
    endtask

    // Reference model: walk each of the 16 lines, find maximal equal runs.
    task automatic computeExpected(output logic [63:0] m, output int cnt, output bit bad);
        int idx [8];
        int s;
        int e;
        logic [2:0] col;
        m = '0;
        bad = 1'b0;
        for (int i = 0; i < 64; i++)
            if (stimBoard[i] == 3'd0 || stimBoard[i] == 3'd7) bad = 1'b1;
        for (int ln = 0; ln < 16; ln++) begin
            for (int k = 0; k < 8; k++)
                idx[k] = (ln < 8) ? ln*8 + k : k*8 + (ln - 8);
            s = 0;
            while (s < 8) begin
                col = stimBoard[idx[s]];
                if (col == 3'd0 || col == 3'd7) begin
                    s++;
                end else begin
                    e = s;
                    while (e < 8 && stimBoard[idx[e]] == col) e++;
                    if (e - s >= RUN_MIN)
                        for (int k = s; k < e; k++) m[idx[k]] = 1'b1;
                    s = e;
                end
            end
        end
        cnt = $countones(m);
    endtask

    // Load stimBoard; returns the edge number of the index-63 handshake.
    task automatic applyStimulus(output int tHandshake);
        int waited;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            waited = 0;
            while (!ifc.cell_ready && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            if (!ifc.cell_ready) checkOutput("cellReadyWait", 64'(ifc.cell_ready), 64'd1);
            ifc.cell_valid = 1'b1;
            ifc.cell_data  = stimBoard[i];
        end
        @(negedge clk);
        ifc.cell_valid = 1'b0;
        tHandshake = cycleCnt;
    endtask

    // Called at the negedge right after handshake edge T.
    task automatic checkResults(input string name, input int tHandshake,
                                input logic [63:0] expMask, input int expCnt,
                                input bit expBad);
        int waited;
        checkOutput({name, ".busy"}, 64'(ifc.busy), 64'd1);
        checkOutput({name, ".readyWhileBusy"}, 64'(ifc.cell_ready), 64'd0);
        waited = 0;
        while (!ifc.done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        // done is high in the cycle ending at edge T+17.
        checkOutput({name, ".doneLatency"}, 64'(cycleCnt + 1 - tHandshake), 64'd17);
        checkOutput({name, ".mask"}, ifc.clear_mask, expMask);
        checkOutput({name, ".cnt"}, 64'(ifc.match_cnt), 64'(expCnt));
`ifdef MATCH_SCANNER_BAD_CELL_EN
        checkOutput({name, ".badCell"}, 64'(ifc.bad_cell), 64'(expBad));
`else
        if (expBad) begin end
`endif
        @(negedge clk);
        checkOutput({name, ".donePulse"}, 64'(ifc.done), 64'd0);
        checkOutput({name, ".readyAfterDone"}, 64'(ifc.cell_ready), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput({name, ".maskHold"}, ifc.clear_mask, expMask);
        checkOutput({name, ".cntHold"}, 64'(ifc.match_cnt), 64'(expCnt));
    endtask

    task automatic runBoard(input string name, input logic [63:0] expMask,
                            input int expCnt, input bit expBad);
        int t;
        applyStimulus(t);
        checkResults(name, t, expMask, expCnt, expBad);
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] m;
        int          cnt;
        bit          bad;
        int          t;
        int          k;
        int          edgeNum;
        int          t63;
        int          t64;
        int          t127;
        int          overlap;
        int          firstDone;
        bit          readyNow;

        vecs[0] = '{"noRun",     0, 64'h0,                   0,  1'b0};
        vecs[1] = '{"row2Run5",  1, 64'h0000_0000_001F_0000, 5,  1'b0};
        vecs[2] = '{"cross",     2, 64'h0000_0008_1C08_0000, 5,  1'b0};
        vecs[3] = '{"row0Zero",  3, 64'h0,                   0,  1'b1};
        vecs[4] = '{"allOnes",   5, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0};
        vecs[5] = '{"row0Seven", 4, 64'h0,                   0,  1'b1};
        vecs[6] = '{"runOfTwo",  6, 64'h0,                   0,  1'b0};
        vecs[7] = '{"row7Full",  7, 64'hFF00_0000_0000_0000, 8,  1'b0};
        vecs[8] = '{"col7Edge",  8, 64'h8080_8080_0000_0000, 4,  1'b0};

        ifc.cell_valid = 1'b0;
        ifc.cell_data  = 3'd0;

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.ready", 64'(ifc.cell_ready), 64'd1);
        checkOutput("reset.busy", 64'(ifc.busy), 64'd0);
        checkOutput("reset.done", 64'(ifc.done), 64'd0);
        checkOutput("reset.mask", ifc.clear_mask, 64'd0);
        checkOutput("reset.cnt", 64'(ifc.match_cnt), 64'd0);
`ifdef MATCH_SCANNER_BAD_CELL_EN
        checkOutput("reset.badCell", 64'(ifc.bad_cell), 64'd0);
`endif
        rst_n = 1'b1;

        // Table-driven boards.
        for (int v = 0; v < 9; v++) begin
            buildBoard(vecs[v].kind);
            runBoard(vecs[v].name, vecs[v].expMask, vecs[v].expCnt, vecs[v].expBad);
        end

        // Random boards against the reference model.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 64; i++) begin
                k = int'($urandom_range(0, 15));
                if (k == 0)      stimBoard[i] = 3'd0;
                else if (k == 1) stimBoard[i] = 3'd7;
                else             stimBoard[i] = 3'($urandom_range(1, 3));
            end
            computeExpected(m, cnt, bad);
            runBoard($sformatf("random%0d", n), m, cnt, bad);
        end

        // Reset asserted mid-scan, then a fresh load.
        buildBoard(1);
        applyStimulus(t);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", 64'(ifc.busy), 64'd0);
        checkOutput("midReset.mask", ifc.clear_mask, 64'd0);
        checkOutput("midReset.ready", 64'(ifc.cell_ready), 64'd1);
        checkOutput("midReset.cnt", 64'(ifc.match_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        buildBoard(2);
        runBoard("afterReset", 64'h0000_0008_1C08_0000, 5, 1'b0);

        // Back-to-back boards with cell_valid held high throughout.
        buildBoard(1);
        for (int i = 0; i < 64; i++) seqCells[i] = stimBoard[i];
        buildBoard(2);
        for (int i = 0; i < 64; i++) seqCells[64+i] = stimBoard[i];
        k = 0; t63 = -1; t64 = -1; t127 = -1; overlap = 0; firstDone = 0;
        @(negedge clk);
        ifc.cell_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && k < 128; cyc++) begin
            ifc.cell_data = seqCells[k];
            readyNow = ifc.cell_ready;
            if (ifc.busy && ifc.cell_ready) overlap++;
            if (ifc.done && k == 64) begin
                firstDone++;
                checkOutput("b2b.firstMask", ifc.clear_mask, 64'h0000_0000_001F_0000);
                checkOutput("b2b.firstCnt", 64'(ifc.match_cnt), 64'd5);
            end
            edgeNum = cycleCnt + 1;
            @(negedge clk);
            if (readyNow) begin
                if (k == 63)  t63 = edgeNum;
                if (k == 64)  t64 = edgeNum;
                if (k == 127) t127 = edgeNum;
                k++;
            end
        end
        ifc.cell_valid = 1'b0;
        checkOutput("b2b.cellsAccepted", 64'(k), 64'd128);
        checkOutput("b2b.firstDoneSeen", 64'(firstDone), 64'd1);
        checkOutput("b2b.secondStart", 64'(t64 - t63), 64'd18);
        checkOutput("b2b.busyReadyOverlap", 64'(overlap), 64'd0);
        checkResults("b2b.second", t127, 64'h0000_0008_1C08_0000, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
